// File: rtl/csa_word_sequencer_if.sv
// ----------------------------------------------------------------------------
// csa_word_sequencer_if
//
// Bundles the requester-side and adder-side signals of csa_word_sequencer.
//
// Handshake: the requester raises start with a/b/cin/sub valid; the sequencer
// accepts it only while idle (busy=0) and on that same clock edge latches the
// operands. busy is the "not ready" indication; a start seen while busy=1 is
// dropped, not queued. done pulses for one cycle when sum/cout/ovf are valid.
// The adder side is a plain combinational loop: the sequencer drives
// add_x/add_y/add_c0 from registers and samples add_s/add_c8 at the next edge.
//
// Modports:
//   slave  - sequencer view (inputs: start,a,b,cin,sub,add_s,add_c8)
//   master - environment view (requester plus the shared 8-bit adder)
// ----------------------------------------------------------------------------
interface csa_word_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int N = 8 * WORDS;

    // Requester side
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    // Shared 8-bit adder side
    logic [7:0]   add_x;
    logic [7:0]   add_y;
    logic         add_c0;
    logic [7:0]   add_s;
    logic         add_c8;

    modport slave (
        input  start, a, b, cin, sub, add_s, add_c8,
        output busy, done, sum, cout, ovf, add_x, add_y, add_c0
    );

    modport master (
        output start, a, b, cin, sub, add_s, add_c8,
        input  busy, done, sum, cout, ovf, add_x, add_y, add_c0
    );
endinterface

// File: rtl/csa_word_sequencer.sv
// ----------------------------------------------------------------------------
// csa_word_sequencer
//
// Multi-precision add/subtract controller. One external 8-bit adder is reused
// for WORDS limbs, least significant limb first; each limb's c8 becomes the
// next limb's c0. Subtraction is a + ~b + 1.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any run)
//   bus          csa_word_sequencer_if.slave: start/a/b/cin/sub in,
//                busy/done/sum/cout/ovf out, add_x/add_y/add_c0 to the adder,
//                add_s/add_c8 back from the adder
//   o_dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Timing: start accepted in cycle T -> RUN in T+1..T+WORDS, done in
// T+WORDS+1, next start accepted no earlier than T+WORDS+2.
// ----------------------------------------------------------------------------
module csa_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    csa_word_sequencer_if.slave    bus,
    output logic [1:0]             o_dbg_state
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [IDX_W-1:0]        r_idx;
    logic [WORDS-1:0][7:0]   r_a;
    logic [WORDS-1:0][7:0]   r_bx;      // b, or ~b for subtraction
    logic                    r_carry;
    logic [WORDS-1:0][7:0]   r_sum;
    logic                    r_cout;
    logic                    r_ovf;

    logic                    w_accept;
    logic                    w_capture;
    logic                    w_last;
    logic                    w_busy;
    logic                    w_done;
    logic [7:0]              w_add_x;
    logic [7:0]              w_add_y;
    logic                    w_add_c0;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. The adder operands are muxed from
    // registers only, so there is no path from requester inputs to the
    // adder pins.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_add_x      = 8'd0;
        w_add_y      = 8'd0;
        w_add_c0     = 1'b0;
        w_last       = (r_idx == IDX_W'(WORDS - 1));

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_busy    = 1'b1;
                w_capture = 1'b1;
                w_add_x   = r_a[r_idx];
                w_add_y   = r_bx[r_idx];
                w_add_c0  = r_carry;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, per-limb capture, final flags.
    // sum is cleared on accept so partial results are never mistaken for
    // the previous operation's answer; cout/ovf keep their old value until
    // the last limb is captured.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_bx    <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= bus.a;
            r_bx    <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_sum   <= '0;
        end else if (w_capture) begin
            r_sum[r_idx] <= bus.add_s;
            r_carry      <= bus.add_c8;
            r_idx        <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= bus.add_c8;
                // Overflow: operands of equal sign produced a result of the
                // other sign (uses the effective operand ~b for subtract).
                r_ovf  <= (r_a[WORDS-1][7] == r_bx[WORDS-1][7]) &&
                          (bus.add_s[7] != r_a[WORDS-1][7]);
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.ovf     = r_ovf;
    assign bus.add_x   = w_add_x;
    assign bus.add_y   = w_add_y;
    assign bus.add_c0  = w_add_c0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_csa_word_sequencer.sv
module tb_csa_word_sequencer;
    localparam int WORDS = 4;
    localparam int N     = 8 * WORDS;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_word_sequencer_if #(.WORDS(WORDS)) bus ();
    logic [1:0] dbg_state;

    csa_word_sequencer #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // The shared 8-bit adder lives in the environment.
    assign {bus.add_c8, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {8'd0, bus.add_c0};

    int n_vec  = 0;
    int n_fail = 0;

    // {cout, ovf, sum} expected at each done pulse, hand-computed
    logic [N+1:0] exp_q[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] low_mask(input int bits);
        if (bits >= N) return '1;
        return (N'(1) << bits) - N'(1);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: tracks cycles since acceptance and derives every
    // visible value from whole-word arithmetic on the latched operands.
    // ------------------------------------------------------------------
    int           m_cnt   = 0;     // 0 idle, 1..WORDS limb k running, WORDS+1 done
    logic         m_valid = 1'b0;
    logic [N-1:0] m_a, m_bx, m_sum;
    logic         m_c0, m_cout, m_ovf;
    logic [N:0]   m_full;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_a     = '0;
            m_bx    = '0;
            m_c0    = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_full  = '0;
        end else if (m_valid) begin
            if (m_cnt == 0) begin
                if (bus.start) begin
                    m_a    = bus.a;
                    m_bx   = bus.sub ? ~bus.b : bus.b;
                    m_c0   = bus.sub ? 1'b1 : bus.cin;
                    m_full = {1'b0, m_a} + {1'b0, m_bx} + (N+1)'(m_c0);
                    m_sum  = '0;
                    m_cnt  = 1;
                end
            end else if (m_cnt <= WORDS) begin
                m_sum = m_full[N-1:0] & low_mask(8 * m_cnt);
                if (m_cnt == WORDS) begin
                    m_cout = m_full[N];
                    m_ovf  = (m_a[N-1] == m_bx[N-1]) && (m_full[N-1] != m_a[N-1]);
                end
                m_cnt++;
            end else begin
                m_cnt = 0;
            end
        end
    end

    // Carry entering bit 8*i of the latched addition.
    function automatic logic carry_into(input int i);
        logic [N:0] t;
        t = {1'b0, m_a & low_mask(8 * i)} + {1'b0, m_bx & low_mask(8 * i)} + (N+1)'(m_c0);
        return t[8 * i];
    endfunction

    // ------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic       running;
        logic [7:0] ex, ey;
        logic       ec;
        logic [N+1:0] e;
        if (m_valid) begin
            running = (m_cnt >= 1) && (m_cnt <= WORDS);
            ex = running ? 8'(m_a  >> (8 * (m_cnt - 1))) : 8'd0;
            ey = running ? 8'(m_bx >> (8 * (m_cnt - 1))) : 8'd0;
            ec = running ? carry_into(m_cnt - 1) : 1'b0;
            check("busy",   N'(bus.busy),   N'(m_cnt != 0));
            check("done",   N'(bus.done),   N'(m_cnt == WORDS + 1));
            check("sum",    bus.sum,        m_sum);
            check("cout",   N'(bus.cout),   N'(m_cout));
            check("ovf",    N'(bus.ovf),    N'(m_ovf));
            check("add_x",  N'(bus.add_x),  N'(ex));
            check("add_y",  N'(bus.add_y),  N'(ey));
            check("add_c0", N'(bus.add_c0), N'(ec));
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", N'(1), N'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum",  bus.sum,      e[N-1:0]);
                    check("sb_ovf",  N'(bus.ovf),  N'(e[N]));
                    check("sb_cout", N'(bus.cout), N'(e[N+1]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 3 * WORDS; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout at %0t: got no done, expected done within %0d cycles", $time, 3 * WORDS);
        end
    endtask

    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic icin,
                          input logic isub, input logic [N-1:0] esum, input logic ecout,
                          input logic eovf);
        exp_q.push_back({ecout, eovf, esum});
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = icin;
        bus.sub   = isub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        wait_done();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic add, with and without carry-in
        run_op(32'h0000000C, 32'h00000005, 1'b0, 1'b0, 32'h00000011, 1'b0, 1'b0);
        run_op(32'h0000000C, 32'h00000005, 1'b1, 1'b0, 32'h00000012, 1'b0, 1'b0);
        // Carry ripples through every limb
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        // Subtract with borrow (cin=1 must be ignored), then without
        run_op(32'h00000064, 32'h000000C8, 1'b1, 1'b1, 32'hFFFFFF9C, 1'b0, 1'b0);
        run_op(32'h000000C8, 32'h00000064, 1'b0, 1'b1, 32'h00000064, 1'b1, 1'b0);
        // Signed overflow on add and on subtract
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        // Mixed carries across limbs
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0);

        // start held through the whole run with operands changing every cycle
        exp_q.push_back({1'b0, 1'b0, 32'h11223345});
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h01020304;
        bus.b     = 32'h10203040;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            bus.cin = 1'(k);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the second RUN cycle aborts the run
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'hFFFFFFFF;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", N'(bus.busy), N'(0));
        check("abort_sum",  bus.sum,      N'(0));
        repeat (WORDS + 2) @(negedge clk);

        // A new operation completes normally after the abort
        run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", N'(exp_q.size()), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got no end of test, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
